// File: rtl/branch_redirect_pkg.sv
// rtl/branch_redirect_pkg.sv - shared constants, branch op codes and FSM encoding for branch_redirect
package branch_redirect_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] TGT_MASK     = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_BEQ  = 3'b001,
      OP_BNE  = 3'b010,
      OP_BLEZ = 3'b011,
      OP_BGTZ = 3'b100,
      OP_BLTZ = 3'b101
   } branch_op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   // Conditional branches are the only ops that feed the performance counters
   function automatic logic is_cond_branch(input logic [2:0] op);
      return (op >= 3'(OP_BEQ)) && (op <= 3'(OP_BLTZ));
   endfunction

endpackage

// File: rtl/branch_redirect_if.sv
// rtl/branch_redirect_if.sv - ID-stage decision inputs and fetch-side outputs of branch_redirect
interface branch_redirect_if #(parameter int CNT_W = 16);

   logic              i_id_valid;
   logic              i_id_stall;
   logic              i_if_hold;
   logic [2:0]        i_branch_op;
   logic              i_branch_taken;
   logic [31:0]       i_branch_target;
   logic              i_jump;
   logic [31:0]       i_jump_target;
   logic [31:0]       o_pc;
   logic              o_if_flush;
   logic              o_redirect;
   logic [CNT_W-1:0]  o_branch_cnt;
   logic [CNT_W-1:0]  o_taken_cnt;

   modport master (
      output i_id_valid, i_id_stall, i_if_hold, i_branch_op, i_branch_taken,
             i_branch_target, i_jump, i_jump_target,
      input  o_pc, o_if_flush, o_redirect, o_branch_cnt, o_taken_cnt
   );

   modport slave (
      input  i_id_valid, i_id_stall, i_if_hold, i_branch_op, i_branch_taken,
             i_branch_target, i_jump, i_jump_target,
      output o_pc, o_if_flush, o_redirect, o_branch_cnt, o_taken_cnt
   );

endinterface

// File: rtl/branch_redirect_sat_counter.sv
// rtl/branch_redirect_sat_counter.sv - W-bit up counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // Count up on inc, holding once every bit is set
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - PC register, IF/ID flush and pending-redirect FSM with branch counters
module branch_redirect
   import branch_redirect_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   branch_redirect_if.slave bus
);

   state_e       state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pend_pc_q;
   logic         redirect_q;

   logic         resolve;
   logic         redir_req;
   logic [31:0]  target;
   logic [31:0]  pc_inc_d;
   logic         cnt_br_inc;
   logic         cnt_tk_inc;

   // A branch decision is only final once ID holds a real, unstalled instruction
   assign resolve   = bus.i_id_valid & ~bus.i_id_stall;
   assign redir_req = resolve & (bus.i_jump |
                      ((bus.i_branch_op != 3'(OP_NONE)) & bus.i_branch_taken));
   // Jump wins over branch; targets are always word aligned
   assign target    = (bus.i_jump ? bus.i_jump_target : bus.i_branch_target) & TGT_MASK;
   assign pc_inc_d  = pc_q + PC_INC;

   // While PEND the ID stage is behind the flush, so its inputs are not counted
   assign cnt_br_inc = resolve & is_cond_branch(bus.i_branch_op) & (state_q == ST_RUN);
   assign cnt_tk_inc = cnt_br_inc & bus.i_branch_taken;

   // PC update: take a target, park it across a fetch hold, or step sequentially
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         pend_pc_q  <= '0;
         redirect_q <= 1'b0;
      end else begin
         redirect_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (redir_req) begin
                  if (!bus.i_if_hold) begin
                     pc_q       <= target;
                     redirect_q <= 1'b1;
                  end else begin
                     pend_pc_q  <= target;
                     state_q    <= ST_PEND;
                  end
               end else if (!bus.i_if_hold) begin
                  pc_q <= pc_inc_d;
               end
            end
            ST_PEND: begin
               if (!bus.i_if_hold) begin
                  pc_q       <= pend_pc_q;
                  redirect_q <= 1'b1;
                  state_q    <= ST_RUN;
               end
            end
         endcase
      end
   end

   assign bus.o_pc       = pc_q;
   assign bus.o_redirect = redirect_q;
   assign bus.o_if_flush = (state_q == ST_PEND) | redir_req;

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .inc   (cnt_br_inc),
      .count (bus.o_branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .inc   (cnt_tk_inc),
      .count (bus.o_taken_cnt)
   );

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - self-checking bench for branch_redirect
module tb_branch_redirect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst4_n;

   branch_redirect_if #(.CNT_W(16)) bi();
   branch_redirect_if #(.CNT_W(4))  bi4();

   branch_redirect #(.RESET_PC(32'h0040_0000), .CNT_W(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bi.slave)
   );

   branch_redirect #(.RESET_PC(32'h0040_0000), .CNT_W(4)) dut4 (
      .i_clk   (clk),
      .i_rst_n (rst4_n),
      .bus     (bi4.slave)
   );

   typedef struct {
      logic        v, s, h;
      logic [2:0]  op;
      logic        t;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic [31:0] pc;
      logic        fl, rd;
      logic [15:0] bc, tc;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic s, input logic h, input logic [2:0] op,
                               input logic t, input logic [31:0] bt, input logic j,
                               input logic [31:0] jt, input logic [31:0] pc, input logic fl,
                               input logic rd, input logic [15:0] bc, input logic [15:0] tc);
      vec_t r;
      r.v = v; r.s = s; r.h = h; r.op = op; r.t = t; r.bt = bt; r.j = j; r.jt = jt;
      r.pc = pc; r.fl = fl; r.rd = rd; r.bc = bc; r.tc = tc;
      return r;
   endfunction

   task automatic drive(input logic v, input logic s, input logic h, input logic [2:0] op,
                        input logic t, input logic [31:0] bt, input logic j, input logic [31:0] jt);
      bi.i_id_valid      = v;
      bi.i_id_stall      = s;
      bi.i_if_hold       = h;
      bi.i_branch_op     = op;
      bi.i_branch_taken  = t;
      bi.i_branch_target = bt;
      bi.i_jump          = j;
      bi.i_jump_target   = jt;
   endtask

   task automatic idle(input logic h);
      drive(1'b0, 1'b0, h, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[18];

   // reference model state
   logic [31:0] m_pc, m_pend;
   bit          m_pending, m_redir;
   int          m_bc, m_tc;

   initial begin
      rst4_n = 1'b0;
      bi4.i_id_valid = 1'b0; bi4.i_id_stall = 1'b0; bi4.i_if_hold = 1'b0;
      bi4.i_branch_op = 3'b000; bi4.i_branch_taken = 1'b0; bi4.i_branch_target = 32'h0;
      bi4.i_jump = 1'b0; bi4.i_jump_target = 32'h0;

      //            v  s  h  op      t  bt            j  jt            pc            fl rd bc tc
      tbl[0]  = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0004, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0008, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_000C, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 3'b001, 1, 32'h0040_0100, 0, 32'h0,       32'h0040_0100, 1, 1, 1, 1);
      tbl[4]  = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0104, 0, 0, 1, 1);
      tbl[5]  = mk(1, 0, 1, 3'b001, 1, 32'h0040_0100, 0, 32'h0,       32'h0040_0104, 1, 0, 2, 2);
      tbl[6]  = mk(0, 0, 1, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0104, 1, 0, 2, 2);
      tbl[7]  = mk(0, 0, 1, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0104, 1, 0, 2, 2);
      tbl[8]  = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0100, 1, 1, 2, 2);
      tbl[9]  = mk(1, 1, 0, 3'b010, 1, 32'h0040_0300, 0, 32'h0,       32'h0040_0104, 0, 0, 2, 2);
      tbl[10] = mk(1, 1, 0, 3'b010, 1, 32'h0040_0300, 0, 32'h0,       32'h0040_0108, 0, 0, 2, 2);
      tbl[11] = mk(1, 0, 0, 3'b010, 1, 32'h0040_0300, 0, 32'h0,       32'h0040_0300, 1, 1, 3, 3);
      tbl[12] = mk(1, 0, 0, 3'b100, 0, 32'h0040_0500, 0, 32'h0,       32'h0040_0304, 0, 0, 4, 3);
      tbl[13] = mk(1, 0, 0, 3'b000, 1, 32'h0040_0800, 1, 32'h0040_0203, 32'h0040_0200, 1, 1, 4, 3);
      tbl[14] = mk(1, 0, 0, 3'b110, 1, 32'h0040_0600, 0, 32'h0,       32'h0040_0600, 1, 1, 4, 3);
      tbl[15] = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0040_0604, 0, 0, 4, 3);
      tbl[16] = mk(1, 0, 0, 3'b000, 0, 32'h0,        1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 1, 4, 3);
      tbl[17] = mk(0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 4, 3);

      // reset state
      do_reset();
      chk("reset_pc", bi.o_pc, 32'h0040_0000);
      chk("reset_redirect", {31'h0, bi.o_redirect}, 32'h0);
      chk("reset_flush", {31'h0, bi.o_if_flush}, 32'h0);
      chk("reset_bcnt", {16'h0, bi.o_branch_cnt}, 32'h0);
      chk("reset_tcnt", {16'h0, bi.o_taken_cnt}, 32'h0);

      // table-driven directed vectors
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].h, tbl[i].op, tbl[i].t, tbl[i].bt, tbl[i].j, tbl[i].jt);
         #1;
         chk($sformatf("vec%0d_flush", i), {31'h0, bi.o_if_flush}, {31'h0, tbl[i].fl});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_pc", i), bi.o_pc, tbl[i].pc);
         chk($sformatf("vec%0d_redirect", i), {31'h0, bi.o_redirect}, {31'h0, tbl[i].rd});
         chk($sformatf("vec%0d_bcnt", i), {16'h0, bi.o_branch_cnt}, {16'h0, tbl[i].bc});
         chk($sformatf("vec%0d_tcnt", i), {16'h0, bi.o_taken_cnt}, {16'h0, tbl[i].tc});
      end

      // reset while PEND drops the parked target
      do_reset();
      drive(1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 32'h0040_0700, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      idle(1'b1);
      #1;
      chk("pend_flush", {31'h0, bi.o_if_flush}, 32'h1);
      rst_n = 1'b0;
      idle(1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rstpend_pc", bi.o_pc, 32'h0040_0000);
      chk("rstpend_flush", {31'h0, bi.o_if_flush}, 32'h0);
      chk("rstpend_bcnt", {16'h0, bi.o_branch_cnt}, 32'h0);
      @(posedge clk);
      #1;
      chk("rstpend_next_pc", bi.o_pc, 32'h0040_0004);
      chk("rstpend_next_redirect", {31'h0, bi.o_redirect}, 32'h0);

      // randomized run against the behavioural model
      do_reset();
      m_pc = 32'h0040_0000; m_pend = 32'h0; m_pending = 0; m_redir = 0; m_bc = 0; m_tc = 0;
      for (int n = 0; n < 600; n++) begin
         logic v, s, h, t, j, resolve, req;
         logic [2:0] op;
         logic [31:0] bt, jt, tgt;
         v  = ($urandom_range(0, 3) != 0);
         s  = ($urandom_range(0, 3) == 0);
         h  = ($urandom_range(0, 2) == 0);
         op = 3'($urandom_range(0, 7));
         t  = 1'($urandom_range(0, 1));
         j  = ($urandom_range(0, 5) == 0);
         bt = $urandom;
         jt = $urandom;
         resolve = v && !s;
         req = resolve && (j || (op != 3'b000 && t));
         tgt = j ? jt : bt;
         tgt[1:0] = 2'b00;
         drive(v, s, h, op, t, bt, j, jt);
         #1;
         chk("rand_flush", {31'h0, bi.o_if_flush}, {31'h0, (m_pending || req)});
         if (m_pending) begin
            if (!h) begin
               m_pc = m_pend; m_redir = 1; m_pending = 0;
            end else begin
               m_redir = 0;
            end
         end else begin
            if (resolve && op >= 3'd1 && op <= 3'd5) begin
               if (m_bc < 65535) m_bc++;
               if (t && m_tc < 65535) m_tc++;
            end
            if (req && !h) begin
               m_pc = tgt; m_redir = 1;
            end else if (req) begin
               m_pending = 1; m_pend = tgt; m_redir = 0;
            end else begin
               m_redir = 0;
               if (!h) m_pc = m_pc + 32'd4;
            end
         end
         @(posedge clk);
         #1;
         chk("rand_pc", bi.o_pc, m_pc);
         chk("rand_redirect", {31'h0, bi.o_redirect}, {31'h0, m_redir});
         chk("rand_bcnt", {16'h0, bi.o_branch_cnt}, 32'(m_bc));
         chk("rand_tcnt", {16'h0, bi.o_taken_cnt}, 32'(m_tc));
      end

      // 4-bit counters saturate after 15 taken branches
      rst4_n = 1'b1;
      bi4.i_id_valid = 1'b1;
      bi4.i_branch_op = 3'b001;
      bi4.i_branch_taken = 1'b1;
      bi4.i_branch_target = 32'h0040_0100;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("sat_bcnt%0d", k), {28'h0, bi4.o_branch_cnt}, (k > 15) ? 32'd15 : 32'(k));
         chk($sformatf("sat_tcnt%0d", k), {28'h0, bi4.o_taken_cnt}, (k > 15) ? 32'd15 : 32'(k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

PC-update and front-end redirect stage, directly downstream of the ID-stage branch decision. Consumes the taken/not-taken result and the branch/jump target, owns the PC register, and generates the IF/ID flush. Holds one pending redirect across fetch stalls. Keeps saturating counters of resolved and taken conditional branches for the performance-counter block.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- CNT_W, 16, width of each branch counter
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  synchronous reset, active-low
- i_id_valid  in  1  ID stage holds a real instruction, not a bubble
- i_id_stall  in  1  ID held by hazard unit; branch decision not final
- i_if_hold  in  1  fetch cannot advance (imem not ready); PC must not change
- i_branch_op  in  3  branch type in ID: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz
- i_branch_taken  in  1  taken result for the instruction in ID
- i_branch_target  in  32  conditional-branch target
- i_jump  in  1  unconditional jump in ID
- i_jump_target  in  32  jump target
- o_pc  out  32  current fetch PC, registered
- o_if_flush  out  1  squash the IF/ID latch this cycle
- o_redirect  out  1  registered pulse: PC was loaded from a target last edge
- o_branch_cnt  out  CNT_W  resolved conditional branches, saturating
- o_taken_cnt  out  CNT_W  taken conditional branches, saturating

## Operation
- Resolve = i_id_valid & ~i_id_stall. Redirect request = resolve & (i_jump | (i_branch_op != 000 & i_branch_taken)).
- Target = jump target if i_jump, else branch target. If both are set, i_jump wins. Bits [1:0] are forced to 0.
- FSM has two states, RUN and PEND.
- RUN, redirect request, ~i_if_hold: o_pc <- target; o_redirect <- 1; stay RUN.
- RUN, redirect request, i_if_hold: latch target into pend_pc; go to PEND; o_pc unchanged.
- RUN, no request, ~i_if_hold: o_pc <- o_pc + 4. Addition is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- RUN, no request, i_if_hold: o_pc unchanged.
- PEND, ~i_if_hold: o_pc <- pend_pc; o_redirect <- 1; go to RUN.
- PEND, i_if_hold: stay PEND.
- New ID inputs in PEND are ignored. ID is stalled behind the flush, so no new resolve can occur there.
- o_if_flush (combinational) = (RUN & redirect request) | PEND.
- Counters: on resolve with i_branch_op in 001..101, o_branch_cnt += 1. If also i_branch_taken, o_taken_cnt += 1. Both saturate at all-ones. Jumps and ops 110/111 are not counted.

## Timing
- Reset, when i_rst_n is low at an edge: o_pc = RESET_PC, state RUN, pend_pc = 0, o_redirect = 0, both counters 0. o_if_flush is 0 from the first cycle after reset.
- Reset mid-PEND discards the pending target.
- Redirect latency: request at edge N (no hold) gives o_pc = target after edge N. o_redirect is high for the cycle after edge N. o_if_flush is high in the cycle before edge N.
- i_id_stall high suppresses both the redirect and counting, even if i_branch_taken is high.
- Redirect with hold: o_if_flush stays high for every PEND cycle. The target is applied at the first edge where hold is low.
- Counters update one edge after resolve, independent of i_if_hold.

## Structure
- Shared package holds: RESET_PC, branch_op codes 000..101, RUN/PEND state encoding, PC increment constant 4.
- Sub-module `sat_counter` (parameter W; inputs clk, rst_n, inc; output count), instantiated twice.
- PC register, pend_pc and the FSM stay in the top level.

## Test plan
- Reset, then 3 free-running cycles: o_pc goes 0040_0000, 0040_0004, 0040_0008, 0040_000C; o_if_flush 0; counters 0.
- Taken beq (op 001, taken, target 0040_0100) with no stalls: o_if_flush high that cycle; next o_pc = 0040_0100, o_redirect = 1; o_branch_cnt = 1, o_taken_cnt = 1.
- Same branch with i_if_hold high for 3 cycles: FSM in PEND; o_if_flush high for all 4 cycles; o_pc frozen; o_pc = 0040_0100 after hold drops; counters incremented exactly once.
- Taken bne with i_id_stall high for 2 cycles, then low: no redirect and no count during the stall; redirect and count once after release. Not-taken bgtz gives o_branch_cnt +1 and o_taken_cnt +0.
- i_jump and i_branch_taken together, jump target 0040_0203: o_pc = 0040_0200; counters unchanged if op = 000.
- CNT_W = 4, 20 taken branches: both counters stop at 4'hF. Separately, PC at FFFF_FFFC with no request wraps to 0000_0000.
